// File: rtl/aes_encryption.sv
`default_nettype none
// ============================================================================
// Module      : aes_encryption
// Description : Iterative AES-128 forward cipher. The key and plaintext are
//               loaded one byte per clock, then one round per clock with
//               on-the-fly key expansion. The ciphertext is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_encryption (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   input_key,
  input  logic [7:0]   input_MixCol,
  output logic [127:0] encryptedMessage
);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Standard AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bit offset 8*(255-b) in the packed table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   cur_state, nxt_state;
  logic         load_en, init_en, round_en;
  logic [3:0]   byte_cnt, round_cnt;
  logic [127:0] state_reg, key_reg;
  logic [127:0] sub_bytes, shifted, mixed, next_key, round_out;
  logic [31:0]  sub_word, key_temp, nk0, nk1, nk2, nk3;

  // SubBytes over all 16 state bytes; byte k sits at bits [127-8k -: 8].
  genvar gi, gr, gc;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      assign sub_bytes[127-8*gi -: 8] = sbox(state_reg[127-8*gi -: 8]);
    end

    // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
    for (gr = 0; gr < 4; gr++) begin : g_row
      for (gc = 0; gc < 4; gc++) begin : g_col
        assign shifted[127-8*(4*gc+gr) -: 8] =
          sub_bytes[127-8*(4*((gc+gr)%4)+gr) -: 8];
      end
    end

    // MixColumns, one 32-bit column per iteration.
    for (gc = 0; gc < 4; gc++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = shifted[127-32*gc -: 8];
      assign a1 = shifted[119-32*gc -: 8];
      assign a2 = shifted[111-32*gc -: 8];
      assign a3 = shifted[103-32*gc -: 8];
      assign mixed[127-32*gc -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mixed[119-32*gc -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mixed[111-32*gc -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mixed[103-32*gc -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    // SubWord(RotWord(w3)): rotated byte order is w3 bytes 1,2,3,0.
    for (gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_word[31-8*gi -: 8] = sbox(key_reg[31-8*((gi+1)%4) -: 8]);
    end
  endgenerate

  // Next round key, derived from the previous one in the same cycle it is used.
  assign key_temp = sub_word ^ {rcon(round_cnt), 24'h0};
  assign nk0      = key_reg[127:96] ^ key_temp;
  assign nk1      = key_reg[95:64]  ^ nk0;
  assign nk2      = key_reg[63:32]  ^ nk1;
  assign nk3      = key_reg[31:0]   ^ nk2;
  assign next_key = {nk0, nk1, nk2, nk3};

  // The final round skips MixColumns.
  assign round_out = ((round_cnt == 4'd10) ? shifted : mixed) ^ next_key;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= LOAD;
    else     cur_state <= nxt_state;
  end

  // FSM next-state logic.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      LOAD:    if (byte_cnt == 4'd15) nxt_state = INIT;
      INIT:    nxt_state = ROUND;
      ROUND:   if (round_cnt == 4'd10) nxt_state = DONE;
      default: nxt_state = DONE;
    endcase
  end

  // FSM output decode into datapath enables.
  always_comb begin
    load_en  = (cur_state == LOAD);
    init_en  = (cur_state == INIT);
    round_en = (cur_state == ROUND);
  end

  // Datapath: byte capture, initial AddRoundKey, round iteration, result latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= '0;
      key_reg          <= '0;
      byte_cnt         <= '0;
      round_cnt        <= '0;
      encryptedMessage <= '0;
    end else begin
      if (load_en) begin
        key_reg[{~byte_cnt, 3'b000} +: 8]   <= input_key;
        state_reg[{~byte_cnt, 3'b000} +: 8] <= input_MixCol;
        byte_cnt                            <= byte_cnt + 4'd1;
      end
      if (init_en) begin
        state_reg <= state_reg ^ key_reg;
        round_cnt <= 4'd1;
      end
      if (round_en) begin
        state_reg <= round_out;
        key_reg   <= next_key;
        if (round_cnt == 4'd10) encryptedMessage <= round_out;
        else                    round_cnt        <= round_cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_encryption.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_encryption
// Description : Scoreboard bench for aes_encryption using FIPS-197 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_encryption;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   input_key = 8'h00;
  logic [7:0]   input_MixCol = 8'h00;
  logic [127:0] encryptedMessage;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encryption dut (
    .clk              (clk),
    .rst              (rst),
    .input_key        (input_key),
    .input_MixCol     (input_MixCol),
    .encryptedMessage (encryptedMessage)
  );

  always #5 clk = ~clk;

  // Assert reset between edges; the output must clear before any clock edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (encryptedMessage !== 128'h0) begin
      failures++;
      $display("FAIL %s async_clear: got %h expected 0", tag, encryptedMessage);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive the first n bytes, checking the output stays zero after each edge.
  task automatic load_bytes(input logic [127:0] key, input logic [127:0] pt, input int n);
    logic [127:0] k, p;
    k = key;
    p = pt;
    for (int i = 0; i < n; i++) begin
      input_key    = k[127-8*i -: 8];
      input_MixCol = p[127-8*i -: 8];
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (encryptedMessage !== 128'h0) begin
        failures++;
        $display("FAIL zero_load edge %0d: got %h expected 0", i + 1, encryptedMessage);
      end
    end
  endtask

  // Run edges 17..26 with junk inputs (output must stay 0), then edge 27 pops.
  task automatic finish_vector(input string tag);
    logic [127:0] exp;
    for (int e = 17; e <= 26; e++) begin
      input_key    = 8'($urandom);
      input_MixCol = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (encryptedMessage !== 128'h0) begin
        failures++;
        $display("FAIL %s zero_compute edge %0d: got %h expected 0", tag, e, encryptedMessage);
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty: got %h expected queued value", tag, encryptedMessage);
    end else begin
      exp = exp_q.pop_front();
      if (encryptedMessage !== exp) begin
        failures++;
        $display("FAIL %s ciphertext: got %h expected %h", tag, encryptedMessage, exp);
      end
    end
  endtask

  task automatic run_vector(input string tag, input logic [127:0] key,
                            input logic [127:0] pt, input logic [127:0] ct);
    apply_reset(tag);
    exp_q.push_back(ct);
    load_bytes(key, pt, 16);
    finish_vector(tag);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (encryptedMessage !== 128'h0) begin
      failures++;
      $display("FAIL reset_state: got %h expected 0", encryptedMessage);
    end
  endtask

  task automatic test_fips_b();
    run_vector("fips_b", KEY_B, PT_B, CT_B);
  endtask

  task automatic test_fips_c1();
    run_vector("fips_c1", KEY_C, PT_C, CT_C);
  endtask

  task automatic test_all_zero();
    run_vector("all_zero", 128'h0, 128'h0, CT_Z);
  endtask

  // After DONE the result must hold while the inputs toggle.
  task automatic test_hold();
    run_vector("hold", KEY_B, PT_B, CT_B);
    for (int c = 0; c < 22; c++) begin
      input_key    = 8'($urandom);
      input_MixCol = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (encryptedMessage !== CT_B) begin
        failures++;
        $display("FAIL hold cycle %0d: got %h expected %h", c, encryptedMessage, CT_B);
      end
    end
  endtask

  // Reset after 7 bytes of one vector, then a full load of another.
  task automatic test_reset_mid_load();
    apply_reset("mid_load_pre");
    load_bytes(KEY_B, PT_B, 7);
    run_vector("mid_load", KEY_C, PT_C, CT_C);
  endtask

  // Reset while round 5 is pending, then a fresh full vector.
  task automatic test_reset_mid_round();
    apply_reset("mid_round_pre");
    load_bytes(KEY_C, PT_C, 16);
    for (int e = 17; e <= 21; e++) begin
      @(posedge clk);
      @(negedge clk);
    end
    run_vector("mid_round", KEY_B, PT_B, CT_B);
  endtask

  // Two vectors with no idle time between them beyond the reset.
  task automatic test_back_to_back();
    run_vector("b2b_1", 128'h0, 128'h0, CT_Z);
    run_vector("b2b_2", KEY_C, PT_C, CT_C);
  endtask

  initial begin
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_all_zero();
    test_hold();
    apply_reset("after_done");
    test_reset_mid_load();
    test_reset_mid_round();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
